set_query_dispatcher: RTL

// Front-end command stage for the SET point-counting engine. It queues set queries (three circle

---
 rtl/set_query_dispatcher.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/set_query_dispatcher.sv
// Command front-end for the SET point-counting engine.
// Queues set queries in a small FIFO, issues them one at a time to SET over its
// en/busy/valid handshake, and returns each count with its caller tag over a
// valid/ready result port. At most one query is in flight plus one held result.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   i_cmd_*            command input: valid, central {xa,ya,xb,yb,xc,yc}, radius {ra,rb,rc}, mode, tag
//   o_cmd_ready        FIFO can accept a command (not full)
//   o_set_en           one-cycle start pulse to SET
//   o_set_central/radius/mode  registered query payload to SET
//   i_set_busy         SET busy
//   i_set_valid        SET done pulse, qualifies i_set_candidate
//   i_set_candidate    SET count
//   o_res_valid        result held until accepted with i_res_ready
//   o_res_count        candidate count (0 on timeout)
//   o_res_tag          tag of the completed command
//   o_res_err          1 when the query timed out

package set_query_dispatcher_pkg;
    localparam int unsigned CENTRAL_W = 24;
    localparam int unsigned RADIUS_W  = 12;
    localparam int unsigned MODE_W    = 2;
    localparam int unsigned COUNT_W   = 8;

    typedef struct packed {
        logic [CENTRAL_W-1:0] central;
        logic [RADIUS_W-1:0]  radius;
        logic [MODE_W-1:0]    mode;
    } set_query_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;
endpackage

module set_query_dispatcher
    import set_query_dispatcher_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 80
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [CENTRAL_W-1:0] i_cmd_central,
    input  logic [RADIUS_W-1:0]  i_cmd_radius,
    input  logic [MODE_W-1:0]    i_cmd_mode,
    input  logic [TAG_W-1:0]     i_cmd_tag,
    output logic                 o_set_en,
    output logic [CENTRAL_W-1:0] o_set_central,
    output logic [RADIUS_W-1:0]  o_set_radius,
    output logic [MODE_W-1:0]    o_set_mode,
    input  logic                 i_set_busy,
    input  logic                 i_set_valid,
    input  logic [COUNT_W-1:0]   i_set_candidate,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [COUNT_W-1:0]   o_res_count,
    output logic [TAG_W-1:0]     o_res_tag,
    output logic                 o_res_err
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT);

    // FIFO storage and bookkeeping
    set_query_t             r_mem     [DEPTH];
    logic [TAG_W-1:0]       r_tag_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [FILL_W-1:0]      r_fill;
    logic                   r_full;

    // FSM and datapath registers
    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_set_en;
    set_query_t             r_set;
    logic [TAG_W-1:0]       r_pend_tag;
    logic [CNT_W-1:0]       r_wait_cnt;
    logic                   r_res_valid;
    logic [COUNT_W-1:0]     r_res_count;
    logic [TAG_W-1:0]       r_res_tag;
    logic                   r_res_err;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_capture;
    logic                   w_timeout;
    logic                   w_empty;
    logic [FILL_W-1:0]      w_fill_next;
    set_query_t             w_cmd;

    always_comb begin
        w_cmd         = '0;
        w_cmd.central = i_cmd_central;
        w_cmd.radius  = i_cmd_radius;
        w_cmd.mode    = i_cmd_mode;
    end

    // Push is gated only by the registered full flag; a same-cycle pop does not make room.
    assign w_push      = i_cmd_valid & ~r_full;
    assign w_empty     = (r_fill == '0);
    assign w_fill_next = r_fill + FILL_W'(w_push) - FILL_W'(w_pop);

    // FIFO payload write (no reset needed; validity is tracked by the pointers)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]     <= w_cmd;
            r_tag_mem[r_wr_ptr] <= i_cmd_tag;
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Hold off while a result is still waiting, keeping one result slot only.
                if (!w_empty && !r_res_valid && !i_set_busy) begin
                    w_pop        = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_set_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, FIFO pointers, issue payload, wait counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_full      <= 1'b0;
            r_set_en    <= 1'b0;
            r_set       <= '0;
            r_pend_tag  <= '0;
            r_wait_cnt  <= '0;
            r_res_valid <= 1'b0;
            r_res_count <= '0;
            r_res_tag   <= '0;
            r_res_err   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_fill   <= w_fill_next;
            r_full   <= (w_fill_next == FILL_W'(DEPTH));
            // set_en is high exactly while the FSM sits in S_ISSUE
            r_set_en <= w_pop;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                r_set      <= r_mem[r_rd_ptr];
                r_pend_tag <= r_tag_mem[r_rd_ptr];
            end

            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end

            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_count <= i_set_candidate;
                r_res_tag   <= r_pend_tag;
                r_res_err   <= 1'b0;
            end else if (w_timeout) begin
                r_res_valid <= 1'b1;
                r_res_count <= '0;
                r_res_tag   <= r_pend_tag;
                r_res_err   <= 1'b1;
            end else if (r_res_valid && i_res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign o_cmd_ready   = ~r_full;
    assign o_set_en      = r_set_en;
    assign o_set_central = r_set.central;
    assign o_set_radius  = r_set.radius;
    assign o_set_mode    = r_set.mode;
    assign o_res_valid   = r_res_valid;
    assign o_res_count   = r_res_count;
    assign o_res_tag     = r_res_tag;
    assign o_res_err     = r_res_err;

endmodule
